// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: handshaked SRAM-like fetch port, bounded outstanding
// requests, branch redirect with stale-response discard, and a small instruction buffer.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        ds_allowin
);

  localparam int IB_AW = $clog2(IBUF_DEPTH);
  localparam int IB_CW = $clog2(IBUF_DEPTH + 1);
  localparam int PQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {
    BOOT,
    RUN
  } run_state_t;

  run_state_t state, state_next;

  logic [31:0]      fetch_pc;
  logic [31:0]      stale_addr;
  logic             req_stale;
  logic             req_held;
  logic [OC_W-1:0]  live_cnt;
  logic [OC_W-1:0]  discard_cnt;
  logic [OC_W-1:0]  live_after;
  logic [OC_W-1:0]  discard_after;
  logic [OC_W-1:0]  live_next;
  logic [OC_W-1:0]  discard_next;

  logic [31:0]      pend_pc [MAX_OUTSTANDING];
  logic [PQ_AW-1:0] pend_wr;
  logic [PQ_AW-1:0] pend_rd;

  logic [31:0]      ibuf_pc   [IBUF_DEPTH];
  logic [31:0]      ibuf_inst [IBUF_DEPTH];
  logic [IB_AW-1:0] ibuf_head;
  logic [IB_AW-1:0] ibuf_tail;
  logic [IB_CW-1:0] ibuf_cnt;

  logic credit_ok;
  logic issue_ok;
  logic accept;
  logic resp_keep;
  logic resp_drop;
  logic ib_push;
  logic ib_pop;

  assign inst_sram_wr   = 1'b0;
  assign inst_sram_addr = req_stale ? stale_addr : fetch_pc;

  assign fs_valid = (ibuf_cnt != '0);
  assign fs_pc    = ibuf_pc[ibuf_head];
  assign fs_inst  = ibuf_inst[ibuf_head];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // A request already presented must stay up until accepted; credit only gates new ones.
  always_comb begin
    state_next    = state;
    inst_sram_req = 1'b0;
    credit_ok     = (32'(ibuf_cnt) + 32'(live_cnt)) < 32'(IBUF_DEPTH);
    issue_ok      = (32'(live_cnt) + 32'(discard_cnt)) < 32'(MAX_OUTSTANDING);
    case (state)
      BOOT: state_next = RUN;
      RUN:  inst_sram_req = req_held || (issue_ok && credit_ok);
      default: state_next = BOOT;
    endcase
  end

  assign accept    = inst_sram_req && inst_sram_addr_ok;
  assign resp_keep = inst_sram_data_ok && (discard_cnt == '0);
  assign resp_drop = inst_sram_data_ok && (discard_cnt != '0);
  assign ib_push   = resp_keep && !br_taken;
  assign ib_pop    = fs_valid && ds_allowin && !br_taken;

  always_comb begin
    live_after    = live_cnt + OC_W'(accept && !req_stale) - OC_W'(resp_keep);
    discard_after = discard_cnt + OC_W'(accept && req_stale) - OC_W'(resp_drop);
    live_next     = live_after;
    discard_next  = discard_after;
    if (br_taken) begin
      discard_next = discard_after + live_after;
      live_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      stale_addr  <= RESET_PC;
      req_stale   <= 1'b0;
      req_held    <= 1'b0;
      live_cnt    <= '0;
      discard_cnt <= '0;
    end else begin
      live_cnt    <= live_next;
      discard_cnt <= discard_next;
      req_held    <= inst_sram_req && !inst_sram_addr_ok;
      if (br_taken) begin
        fetch_pc <= br_target;
      end else if (accept && !req_stale) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      // Redirect while a request is stuck on the bus: keep presenting the old address.
      if (br_taken && inst_sram_req && !inst_sram_addr_ok) begin
        req_stale  <= 1'b1;
        stale_addr <= inst_sram_addr;
      end else if (accept) begin
        req_stale <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_wr <= '0;
      pend_rd <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pend_pc[i] <= '0;
      end
    end else begin
      if (accept) begin
        pend_pc[pend_wr] <= inst_sram_addr;
        pend_wr <= (pend_wr == PQ_AW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr + PQ_AW'(1);
      end
      if (inst_sram_data_ok) begin
        pend_rd <= (pend_rd == PQ_AW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd + PQ_AW'(1);
      end
    end
  end

  // Instruction buffer; a redirect empties it regardless of same-cycle push or pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ibuf_head <= '0;
      ibuf_tail <= '0;
      ibuf_cnt  <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        ibuf_pc[i]   <= '0;
        ibuf_inst[i] <= '0;
      end
    end else if (br_taken) begin
      ibuf_head <= '0;
      ibuf_tail <= '0;
      ibuf_cnt  <= '0;
    end else begin
      if (ib_push) begin
        ibuf_pc[ibuf_tail]   <= pend_pc[pend_rd];
        ibuf_inst[ibuf_tail] <= inst_sram_rdata;
        ibuf_tail            <= ibuf_tail + IB_AW'(1);
      end
      if (ib_pop) begin
        ibuf_head <= ibuf_head + IB_AW'(1);
      end
      ibuf_cnt <= ibuf_cnt + IB_CW'(ib_push) - IB_CW'(ib_pop);
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_response : assert property (@(posedge clk) disable iff (!resetn)
    inst_sram_data_ok |-> (live_cnt != '0 || discard_cnt != '0));
  a_no_ibuf_overflow : assert property (@(posedge clk) disable iff (!resetn)
    ib_push |-> (ibuf_cnt != IB_CW'(IBUF_DEPTH) || ib_pop));
`endif

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Parametrised instruction-fetch front end for the LoongArch core. It replaces the single-cycle `pc` register and fixed-latency instruction SRAM read with a handshaked SRAM-like port (req/addr_ok/data_ok), a configurable number of outstanding fetches, branch redirect with stale-response discard, and an IBUF_DEPTH-entry instruction buffer feeding the decode stage. It sits between the instruction SRAM bridge and the ID stage.

## Interface
- RESET_PC, 32'h1c000000, PC fetched first after reset
- IBUF_DEPTH, 4, instruction buffer entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, accepted-but-unanswered fetches allowed (≥1)
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_sram_req  out  1  fetch request valid
- inst_sram_wr  out  1  tied 0
- inst_sram_addr  out  32  fetch address, word aligned
- inst_sram_addr_ok  in  1  request accepted this cycle when req=1
- inst_sram_data_ok  in  1  oldest accepted request returns rdata this cycle
- inst_sram_rdata  in  32  instruction data, valid with data_ok
- br_taken  in  1  redirect pulse from ID/EX (one cycle)
- br_target  in  32  redirect PC, valid with br_taken
- fs_valid  out  1  buffer head valid
- fs_pc  out  32  PC of head entry
- fs_inst  out  32  instruction of head entry
- ds_allowin  in  1  decode consumes head when fs_valid=1

## Operation
- State: fetch_pc, outstanding count (live), discard count, pending-PC FIFO (MAX_OUTSTANDING deep), IBUF (IBUF_DEPTH deep, {pc,inst}), flag req_stale.
- Issue: req=1 when outstanding_total < MAX_OUTSTANDING and ibuf_count + live_outstanding < IBUF_DEPTH (credit; guarantees every data_ok has a slot). addr = fetch_pc.
- Once req=1 without addr_ok, req and addr held unchanged until addr_ok (no withdrawal, including across redirect).
- addr_ok & req: push fetch_pc to pending FIFO, fetch_pc += 4 (mod 2^32), outstanding +1; if req_stale, the accepted request is tagged discard (discard +1), fetch_pc unaffected, req_stale cleared.
- data_ok: pop pending FIFO; if discard>0, decrement and drop data; else push {pc, rdata} into IBUF.
- Consume: fs_valid & ds_allowin pops IBUF head.
- Redirect (br_taken): fetch_pc <= br_target; IBUF flushed (concurrent consume and push ignored); all live outstanding requests, including one accepted same cycle and excluding one answered same cycle, move to discard; if req held without addr_ok, req_stale set. New fetch from br_target begins once the held request is accepted.
- Never push to a full IBUF or pop an empty one; data_ok with zero outstanding is a bus protocol error (assertion only).

## Timing
- Reset (async assert, sync-released effect): req=0, addr=RESET_PC, fetch_pc=RESET_PC, counts 0, req_stale=0, fs_valid=0, fs_pc=0, fs_inst=0.
- First req=1 in first clk edge cycle after resetn deasserts.
- data_ok at earliest one cycle after addr_ok; data_ok in cycle N → fs_valid=1 with that entry in cycle N+1 (registered).
- Back-to-back: with addr_ok held 1, data_ok one cycle later and ds_allowin=1, one instruction per cycle sustained.
- Redirect in cycle N → fs_valid=0 in N+1; req with addr=br_target in N+1 if no held request.
- Simultaneous addr_ok, data_ok, consume and redirect in one cycle resolved per Operation rules; counters updated with all events combined.
- Reset mid-operation drops all state; later responses to pre-reset requests are the bridge's responsibility.

## Test plan
- Reset release, addr_ok=1, data_ok one cycle later, ds_allowin=1 → fetch PCs 1c000000, 1c000004, 1c000008 …; fs_pc sequence matches, one per cycle.
- ds_allowin=0 with IBUF_DEPTH=4 → exactly 4 entries buffered, req drops to 0, no overflow; ds_allowin=1 resumes in order.
- Two requests outstanding (1c000000, 1c000004), br_taken with target 1c000100 → both responses dropped; next fs_pc = 1c000100.
- req held for 3 cycles without addr_ok, redirect to 1c000200 in cycle 1 → addr stays 1c000000 until accepted, its data discarded, then req addr=1c000200.
- Redirect same cycle as data_ok and addr_ok → returned instruction dropped, newly accepted request discarded, discard count correct (no spurious fs_valid).
- resetn asserted mid-stream with IBUF full → fs_valid=0, req=0 immediately; after release, fetch restarts at 1c000000.
